// File: rtl/dc_stall_replay_queue_pkg.sv
// Directory-coherence request encoding and the entry format of the stall/replay queue.
package npu_coherence_defines;

    typedef enum logic [2:0] {
        DIR_GETS    = 3'd0,
        DIR_GETM    = 3'd1,
        DIR_PUTS    = 3'd2,
        DIR_PUTM    = 3'd3,
        DIR_PUTE    = 3'd4,
        DIR_UPGRADE = 3'd5
    } directory_request_t;

    localparam int DC_STALL_QUEUE_DEPTH   = 8;
    localparam int DC_STALL_ADDRESS_WIDTH = 32;
    localparam int DC_STALL_SOURCE_WIDTH  = 4;

    typedef struct packed {
        logic                              valid;
        logic                              released;
        logic [DC_STALL_ADDRESS_WIDTH-1:0] address;
        directory_request_t                request;
        logic [DC_STALL_SOURCE_WIDTH-1:0]  source;
    } dc_stall_entry_t;

endpackage

// File: rtl/dc_stall_replay_queue_oldest_select.sv
// Lowest-index-first priority encoder; index 0 is the oldest queue slot.
module dc_stall_oldest_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]         match_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] index_o
);
    localparam int IDX_W = $clog2(N);

    // NOTE: always_comb uses blocking '=' and assigns every output first, so no latch is inferred.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        // Scan youngest to oldest so the lowest matching index wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                found_o = 1'b1;
                index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dc_stall_replay_queue.sv
// Age-ordered park/replay queue for directory requests blocked by a transient block state.
module dc_stall_replay_queue
    import npu_coherence_defines::*;
#(
    parameter int QUEUE_DEPTH   = DC_STALL_QUEUE_DEPTH,
    parameter int ADDRESS_WIDTH = DC_STALL_ADDRESS_WIDTH,
    parameter int SOURCE_WIDTH  = DC_STALL_SOURCE_WIDTH,
    parameter int REQ_WIDTH     = $bits(directory_request_t)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enq_valid,
    output logic                           enq_ready,
    input  logic [ADDRESS_WIDTH-1:0]       enq_address,
    input  logic [REQ_WIDTH-1:0]           enq_request,
    input  logic [SOURCE_WIDTH-1:0]        enq_source,
    input  logic                           release_valid,
    input  logic [ADDRESS_WIDTH-1:0]       release_address,
    output logic                           deq_valid,
    input  logic                           deq_ready,
    output logic [ADDRESS_WIDTH-1:0]       deq_address,
    output logic [REQ_WIDTH-1:0]           deq_request,
    output logic [SOURCE_WIDTH-1:0]        deq_source,
    input  logic [ADDRESS_WIDTH-1:0]       lookup_address,
    output logic                           lookup_hit,
    output logic [$clog2(QUEUE_DEPTH):0]   occupancy,
    output logic                           full,
    output logic                           empty
);
    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Payload fields are sized by the package; the width parameters must keep their defaults.
    dc_stall_entry_t  entries_q [QUEUE_DEPTH];
    dc_stall_entry_t  entries_d [QUEUE_DEPTH];
    dc_stall_entry_t  shifted   [QUEUE_DEPTH];
    dc_stall_entry_t  head;
    logic [CNT_W-1:0] occupancy_q, occupancy_d, enq_slot_wide;
    logic [QUEUE_DEPTH-1:0] deq_match, rel_match;
    logic             deq_found, rel_found, deq_fire, enq_fire, dup_released;
    logic [IDX_W-1:0] deq_idx, rel_idx, enq_slot;

    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            deq_match[i] = entries_q[i].valid && entries_q[i].released;
        end
    end

    dc_stall_oldest_select #(.N(QUEUE_DEPTH)) u_deq_select (
        .match_i (deq_match),
        .found_o (deq_found),
        .index_o (deq_idx)
    );

    assign head        = entries_q[deq_idx];
    assign deq_valid   = deq_found;
    assign deq_address = deq_found ? head.address : '0;
    assign deq_request = deq_found ? head.request : '0;
    assign deq_source  = deq_found ? head.source  : '0;

    assign full      = (occupancy_q == CNT_W'(QUEUE_DEPTH));
    assign empty     = (occupancy_q == '0);
    assign occupancy = occupancy_q;
    assign enq_ready = !full;
    assign deq_fire  = deq_valid && deq_ready;
    assign enq_fire  = enq_valid && enq_ready;

    // Removal first: everything younger than the dequeued slot moves down one place.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            shifted[i] = entries_q[i];
        end
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
            if (deq_fire && (IDX_W'(i) >= deq_idx)) begin
                shifted[i] = entries_q[i + 1];
            end
        end
        if (deq_fire) begin
            shifted[QUEUE_DEPTH-1].valid    = 1'b0;
            shifted[QUEUE_DEPTH-1].released = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            rel_match[i] = release_valid && shifted[i].valid && !shifted[i].released
                           && (shifted[i].address == release_address);
        end
    end

    dc_stall_oldest_select #(.N(QUEUE_DEPTH)) u_rel_select (
        .match_i (rel_match),
        .found_o (rel_found),
        .index_o (rel_idx)
    );

    // The release is resolved before the append, so a same-cycle enqueue is never marked.
    assign enq_slot_wide = occupancy_q - CNT_W'(deq_fire);
    assign enq_slot      = enq_slot_wide[IDX_W-1:0];
    assign occupancy_d   = occupancy_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);

    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entries_d[i] = shifted[i];
        end
        if (rel_found) begin
            entries_d[rel_idx].released = 1'b1;
        end
        if (enq_fire) begin
            entries_d[enq_slot] = '{valid:    1'b1,
                                    released: 1'b0,
                                    address:  enq_address,
                                    request:  directory_request_t'(enq_request),
                                    source:   enq_source};
        end
    end

    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (entries_q[i].valid && (entries_q[i].address == lookup_address)) begin
                lookup_hit = 1'b1;
            end
        end
    end

    // NOTE: only the valid/released flags are reset; payload is don't-care until an entry is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entries_q[i].valid    <= 1'b0;
                entries_q[i].released <= 1'b0;
            end
            occupancy_q <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            occupancy_q <= occupancy_d;
        end
    end

    always_comb begin
        dup_released = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            for (int j = i + 1; j < QUEUE_DEPTH; j++) begin
                if (deq_match[i] && deq_match[j]
                    && (entries_q[i].address == entries_q[j].address)) begin
                    dup_released = 1'b1;
                end
            end
        end
    end

    a_deq_fire_needs_valid: assert property (@(posedge clk) disable iff (reset)
        (deq_ready && !deq_valid) |-> !deq_fire);
    a_no_duplicate_released: assert property (@(posedge clk) disable iff (reset)
        !dup_released);

endmodule

// File: tb/tb_dc_stall_replay_queue.sv
// Directed bench for the directory stall/replay queue with hand-computed expectations.
module tb_dc_stall_replay_queue;
    import npu_coherence_defines::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid, enq_ready;
    logic [31:0] enq_address;
    logic [2:0]  enq_request;
    logic [3:0]  enq_source;
    logic        release_valid;
    logic [31:0] release_address;
    logic        deq_valid, deq_ready;
    logic [31:0] deq_address;
    logic [2:0]  deq_request;
    logic [3:0]  deq_source;
    logic [31:0] lookup_address;
    logic        lookup_hit;
    logic [3:0]  occupancy;
    logic        full, empty;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dc_stall_replay_queue dut (
        .clk             (clk),
        .reset           (reset),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_address     (enq_address),
        .enq_request     (enq_request),
        .enq_source      (enq_source),
        .release_valid   (release_valid),
        .release_address (release_address),
        .deq_valid       (deq_valid),
        .deq_ready       (deq_ready),
        .deq_address     (deq_address),
        .deq_request     (deq_request),
        .deq_source      (deq_source),
        .lookup_address  (lookup_address),
        .lookup_hit      (lookup_hit),
        .occupancy       (occupancy),
        .full            (full),
        .empty           (empty)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input directory_request_t r, input logic [3:0] s);
        enq_valid   = 1'b1;
        enq_address = a;
        enq_request = r;
        enq_source  = s;
        tick();
        enq_valid   = 1'b0;
    endtask

    task automatic rel(input logic [31:0] a);
        release_valid   = 1'b1;
        release_address = a;
        tick();
        release_valid   = 1'b0;
    endtask

    task automatic pop();
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
    endtask

    task automatic expect_deq(input string tag, input logic [31:0] a,
                              input directory_request_t r, input logic [3:0] s);
        check({tag, ".valid"},  deq_valid,   1'b1);
        check({tag, ".addr"},   deq_address, a);
        check({tag, ".req"},    deq_request, r);
        check({tag, ".src"},    deq_source,  s);
    endtask

    task automatic expect_idle_reset_state(input string tag);
        check({tag, ".enq_ready"}, enq_ready,   1'b1);
        check({tag, ".deq_valid"}, deq_valid,   1'b0);
        check({tag, ".deq_addr"},  deq_address, 32'h0);
        check({tag, ".deq_req"},   deq_request, 3'h0);
        check({tag, ".deq_src"},   deq_source,  4'h0);
        check({tag, ".occ"},       occupancy,   4'd0);
        check({tag, ".empty"},     empty,       1'b1);
        check({tag, ".full"},      full,        1'b0);
        check({tag, ".hit"},       lookup_hit,  1'b0);
    endtask

    initial begin
        reset = 1'b1; enq_valid = 1'b0; enq_address = '0; enq_request = '0; enq_source = '0;
        release_valid = 1'b0; release_address = '0; deq_ready = 1'b0; lookup_address = 32'h100;
        tick(); tick();
        reset = 1'b0;
        expect_idle_reset_state("reset");

        // Single park, release, replay.
        push(32'h100, DIR_GETM, 4'd2);
        check("t1.occ", occupancy, 4'd1);
        check("t1.hit", lookup_hit, 1'b1);
        release_valid = 1'b1; release_address = 32'h100;
        #1 check("t1.no_bypass", deq_valid, 1'b0);
        tick(); release_valid = 1'b0;
        expect_deq("t1.deq", 32'h100, DIR_GETM, 4'd2);
        tick();
        expect_deq("t1.hold", 32'h100, DIR_GETM, 4'd2);
        pop();
        check("t1.empty", empty, 1'b1);
        check("t1.deq_valid", deq_valid, 1'b0);

        // Same-address FIFO replay.
        push(32'h100, DIR_GETS, 4'd1);
        push(32'h100, DIR_GETM, 4'd3);
        check("t2.hit", lookup_hit, 1'b1);
        lookup_address = 32'h104;
        #1 check("t2.miss_adjacent", lookup_hit, 1'b0);
        rel(32'h100);
        expect_deq("t2.first", 32'h100, DIR_GETS, 4'd1);
        pop();
        check("t2.occ", occupancy, 4'd1);
        check("t2.second_parked", deq_valid, 1'b0);
        rel(32'h100);
        expect_deq("t2.second", 32'h100, DIR_GETM, 4'd3);
        pop();
        check("t2.empty", empty, 1'b1);

        // Different addresses replay out of global order.
        push(32'h200, DIR_GETS, 4'd4);
        push(32'h300, DIR_PUTM, 4'd5);
        rel(32'h300);
        expect_deq("t3.deq", 32'h300, DIR_PUTM, 4'd5);
        check("t3.occ2", occupancy, 4'd2);
        pop();
        check("t3.occ1", occupancy, 4'd1);
        check("t3.idle", deq_valid, 1'b0);
        lookup_address = 32'h200;
        #1 check("t3.hit200", lookup_hit, 1'b1);
        rel(32'h200);
        expect_deq("t3.deq200", 32'h200, DIR_GETS, 4'd4);
        pop();

        // Fill, refuse while full even alongside a dequeue, then append after compaction.
        for (int i = 0; i < 8; i++) begin
            push(32'h1000 + 32'(i) * 32'h40, DIR_GETS, 4'(i));
        end
        check("t4.full", full, 1'b1);
        check("t4.enq_ready", enq_ready, 1'b0);
        check("t4.occ8", occupancy, 4'd8);
        push(32'h9990, DIR_GETM, 4'd9);
        check("t4.ignored_occ", occupancy, 4'd8);
        lookup_address = 32'h9990;
        #1 check("t4.ignored_hit", lookup_hit, 1'b0);
        rel(32'h1000);
        expect_deq("t4.oldest", 32'h1000, DIR_GETS, 4'd0);
        deq_ready = 1'b1;
        enq_valid = 1'b1; enq_address = 32'h7770; enq_request = DIR_PUTS; enq_source = 4'hA;
        #1 check("t4.ready_when_full", enq_ready, 1'b0);
        tick();
        deq_ready = 1'b0; enq_valid = 1'b0;
        check("t4.occ7", occupancy, 4'd7);
        check("t4.not_full", full, 1'b0);
        lookup_address = 32'h7770;
        #1 check("t4.refused_hit", lookup_hit, 1'b0);
        rel(32'h11C0);
        expect_deq("t4.youngest", 32'h11C0, DIR_GETS, 4'd7);
        deq_ready = 1'b1;
        enq_valid = 1'b1;
        tick();
        deq_ready = 1'b0; enq_valid = 1'b0;
        check("t4.occ_swap", occupancy, 4'd7);
        check("t4.append_hit", lookup_hit, 1'b1);
        check("t4.idle", deq_valid, 1'b0);
        rel(32'h7770);
        expect_deq("t4.appended", 32'h7770, DIR_PUTS, 4'hA);
        reset = 1'b1; tick(); reset = 1'b0;
        lookup_address = 32'h0;
        #1 expect_idle_reset_state("t4.reset");

        // Enqueue and release of the same address in one cycle.
        enq_valid = 1'b1; enq_address = 32'h400; enq_request = DIR_GETM; enq_source = 4'd6;
        release_valid = 1'b1; release_address = 32'h400;
        tick();
        enq_valid = 1'b0; release_valid = 1'b0;
        check("t5.occ", occupancy, 4'd1);
        check("t5.unreleased", deq_valid, 1'b0);
        tick();
        check("t5.still_parked", deq_valid, 1'b0);
        rel(32'h400);
        expect_deq("t5.deq", 32'h400, DIR_GETM, 4'd6);
        pop();

        // Dequeue and release in one cycle: release lands on the survivor after the shift.
        push(32'h500, DIR_GETS, 4'd1);
        push(32'h500, DIR_GETS, 4'd2);
        rel(32'h500);
        deq_ready = 1'b1; release_valid = 1'b1; release_address = 32'h500;
        tick();
        deq_ready = 1'b0; release_valid = 1'b0;
        expect_deq("t6.survivor", 32'h500, DIR_GETS, 4'd2);
        check("t6.occ", occupancy, 4'd1);
        pop();

        // Reset mid-replay.
        push(32'h600, DIR_GETS, 4'd1);
        push(32'h700, DIR_GETM, 4'd2);
        push(32'h800, DIR_PUTS, 4'd3);
        rel(32'h600);
        check("t7.pre_valid", deq_valid, 1'b1);
        lookup_address = 32'h700;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_idle_reset_state("t7.reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dc_stall_replay_queue.md
Name: dc_stall_replay_queue

Overview:
- Parks coherence requests at the directory controller that cannot be served because their block is in a transient directory state.
- Replays them in per-address arrival order once the blocking transaction completes.
- Sits between the directory network-interface input stage and the directory protocol pipeline.
- Counterpart, at the home node, of the L1-side stall decision: it guarantees that stalled directory requests are neither lost nor reordered.

Parameters:
QUEUE_DEPTH, 8, number of parked-request entries (power of two, ≥2)
ADDRESS_WIDTH, 32, block address width
SOURCE_WIDTH, 4, requesting tile id width
REQ_WIDTH, $bits(directory_request_t), encoded request type width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enq_valid  in  1  request to park
enq_ready  out  1  queue can accept (= !full)
enq_address  in  ADDRESS_WIDTH  block address
enq_request  in  REQ_WIDTH  request type (GetS, GetM, PutS, PutM, ...)
enq_source  in  SOURCE_WIDTH  requestor tile
release_valid  in  1  one-cycle pulse: directory transaction completed
release_address  in  ADDRESS_WIDTH  address whose transaction completed
deq_valid  out  1  a released entry is available
deq_ready  in  1  protocol pipeline accepts replay
deq_address  out  ADDRESS_WIDTH  replayed address
deq_request  out  REQ_WIDTH  replayed request
deq_source  out  SOURCE_WIDTH  replayed requestor
lookup_address  in  ADDRESS_WIDTH  address of a new incoming request
lookup_hit  out  1  some valid entry holds lookup_address (combinational)
occupancy  out  $clog2(QUEUE_DEPTH)+1  valid entry count
full  out  1  occupancy == QUEUE_DEPTH
empty  out  1  occupancy == 0

Behaviour:
- Storage: age-ordered array. Index 0 is the oldest entry.
- Entry fields: valid, released, address, request, source.
- Reset (synchronous, any cycle, including mid-replay): all valid and released bits cleared. Outputs: enq_ready=1, deq_valid=0, deq_* fields=0, occupancy=0, empty=1, full=0, lookup_hit=0.
- Enqueue:
  - Fires when enq_valid && enq_ready.
  - Entry is written at the first free slot after compaction, with released=0.
  - No same-cycle bypass to deq.
  - enq_valid while full: ignored. The producer holds its request.
- Release:
  - On release_valid, sets released=1 on the oldest valid entry with address == release_address and released==0.
  - Only one entry is marked per pulse.
  - No match: no effect.
  - An entry enqueued in the same cycle is never marked by that cycle's release.
  - The marked entry produces deq_valid=1 in the next cycle (latency 1).
- Dequeue:
  - deq_* present the oldest entry with valid && released. Combinational from registered state, stable while deq_valid && !deq_ready.
  - Fires on deq_valid && deq_ready. The entry is removed and younger entries shift down one slot in the same update, preserving age order.
- Simultaneous events in one cycle (enq, release, deq):
  - Dequeue is removed first.
  - Release is then evaluated on the remaining entries, oldest-first.
  - Enqueue is appended last.
  - occupancy_next = occupancy + enq_fire − deq_fire.
  - When full, enq_ready=0 even if a dequeue fires that cycle.
- Ordering rule for users: the pipeline parks any new request with lookup_hit=1, even if the block is stable. Together with the release rule, this gives FIFO replay per address.
- Different addresses may replay out of global order.
- Width rule: address compare is full ADDRESS_WIDTH equality. occupancy never exceeds QUEUE_DEPTH.
- Assertions (simulation only):
  - deq_ready must not be sampled as a fire when deq_valid=0.
  - No two released entries with the same address coexist.

Decomposition:
- Package npu_coherence_defines:
  - directory_request_t (existing).
  - New struct dc_stall_entry_t {valid, released, address, request, source}.
  - Localparam DC_STALL_QUEUE_DEPTH.
- Sub-module dc_stall_oldest_select: parameterised lowest-index-first priority encoder over a QUEUE_DEPTH match vector, returning found + index.
- Instantiated twice: once for the release match, once for the dequeue select.

Test Plan:
- Park GetM A=0x100 src 2 → release 0x100 at cycle 10 → deq_valid=1 at cycle 11 with {0x100, GetM, 2}. Entry removed on deq_ready; empty=1.
- Park GetS 0x100 src1, GetM 0x100 src3 → lookup_hit=1 for 0x100. First release replays src1 only; second release replays src3.
- Park 0x200 then 0x300 → release 0x300 → deq outputs 0x300 while 0x200 remains; occupancy 2→1.
- Fill 8 entries → full=1, enq_ready=0. Same-cycle deq and enq → enq not accepted, occupancy 7.
- Same cycle: enq 0x400 + release 0x400 with no prior 0x400 entry → new entry stays unreleased; deq_valid=0 next cycle.
- Assert reset with 3 parked entries and deq_valid=1 → next cycle deq_valid=0, occupancy=0, empty=1, lookup_hit=0.
